// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the multiply/divide unit. Holds the
//               MDU_OP_* operation encodings, the FSM state type and small
//               opcode-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Multiply/divide unit operation codes
    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

    // Any encoding above MTLO is not an operation
    function automatic logic mdu_op_valid(input logic [2:0] op);
        return (op <= MDU_OP_MTLO);
    endfunction

    // Operations that run through the iterative datapath
    function automatic logic mdu_op_iter(input logic [2:0] op);
        return (op <= MDU_OP_DIVU);
    endfunction

    function automatic logic mdu_op_signed(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

    function automatic logic mdu_op_div(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module      : muldiv
// Description : Iterative HI/LO multiply/divide unit. Radix-2, one step per
//               cycle over a shared 2*WORD_SIZE+1-bit shift register and a
//               single WORD_SIZE+1-bit adder/subtractor. Signed operations
//               iterate on magnitudes and are sign-corrected in FIN.
//               Build option: define MULDIV_DIV_EN to include the divider;
//               without it DIV/DIVU complete with div_zero set and leave
//               HI/LO untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int c_W     = WORD_SIZE;
    localparam int c_CNT_W = $clog2(WORD_SIZE);

    mdu_state_t           r_state, w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*c_W:0]       r_acc, w_acc_step;
    logic [c_W-1:0]       r_b, r_hi, r_lo;
    logic [c_W-1:0]       w_a_mag, w_b_mag, w_fin_hi, w_fin_lo;
    logic [2*c_W-1:0]     w_prod;
    logic [c_W:0]         w_add_x, w_sum;
    logic [2:0]           r_op;
    logic                 r_neg_q, r_done, r_div_zero;
    logic                 w_accept, w_a_neg, w_b_neg, w_r_div, w_fin_wr, w_fin_dz;
`ifdef MULDIV_DIV_EN
    logic [c_W-1:0]       r_a;
    logic                 r_neg_r, r_b_zero;
`endif

    assign w_accept = start && (r_state == IDLE);
    assign w_a_neg  = mdu_op_signed(op) && a[c_W-1];
    assign w_b_neg  = mdu_op_signed(op) && b[c_W-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_r_div  = mdu_op_div(r_op);

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state: iterative ops run CALC for WORD_SIZE cycles, then one FIN cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && mdu_op_iter(op)) w_next_state = CALC;
            CALC:    if (r_cnt == '0) w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Shared adder/subtractor and one radix-2 step of the shift register.
    // Multiply: add multiplicand to the upper half when the LSB is set, shift right.
    // Divide: shift left, trial-subtract the divisor, keep it if non-negative.
    always_comb begin
`ifdef MULDIV_DIV_EN
        w_add_x = w_r_div ? r_acc[2*c_W-1:c_W-1] : {1'b0, r_acc[2*c_W-1:c_W]};
        w_sum   = w_r_div ? (w_add_x - {1'b0, r_b}) : (w_add_x + {1'b0, r_b});
        if (w_r_div)
            w_acc_step = w_sum[c_W] ? {r_acc[2*c_W-1:0], 1'b0}
                                    : {w_sum, r_acc[c_W-2:0], 1'b1};
        else
            w_acc_step = r_acc[0] ? {1'b0, w_sum, r_acc[c_W-1:1]}
                                  : {1'b0, r_acc[2*c_W:1]};
`else
        w_add_x    = {1'b0, r_acc[2*c_W-1:c_W]};
        w_sum      = w_add_x + {1'b0, r_b};
        w_acc_step = r_acc[0] ? {1'b0, w_sum, r_acc[c_W-1:1]}
                              : {1'b0, r_acc[2*c_W:1]};
`endif
    end

    // Operand capture at acceptance and iteration in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_a      <= '0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
`endif
        end else if (w_accept && mdu_op_iter(op)) begin
            r_acc    <= {{(c_W+1){1'b0}}, w_a_mag};
            r_cnt    <= c_CNT_W'(WORD_SIZE - 1);
            r_b      <= w_b_mag;
            r_op     <= op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_a      <= a;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (b == '0);
`endif
        end else if (r_state == CALC) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sign correction and final HI/LO values presented during FIN
    always_comb begin
        w_fin_hi = r_hi;
        w_fin_lo = r_lo;
        w_fin_wr = 1'b0;
        w_fin_dz = 1'b0;
        w_prod   = r_neg_q ? -r_acc[2*c_W-1:0] : r_acc[2*c_W-1:0];
        if (!w_r_div) begin
            w_fin_wr = 1'b1;
            w_fin_hi = w_prod[2*c_W-1:c_W];
            w_fin_lo = w_prod[c_W-1:0];
        end else begin
`ifdef MULDIV_DIV_EN
            w_fin_wr = 1'b1;
            if (r_b_zero) begin
                w_fin_hi = r_a;
                w_fin_lo = '1;
                w_fin_dz = 1'b1;
            end else begin
                w_fin_lo = r_neg_q ? -r_acc[c_W-1:0] : r_acc[c_W-1:0];
                w_fin_hi = r_neg_r ? -r_acc[2*c_W-1:c_W] : r_acc[2*c_W-1:c_W];
            end
`else
            w_fin_dz = 1'b1;
`endif
        end
    end

    // HI/LO: direct moves at acceptance, results only on the FIN->IDLE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && (op == MDU_OP_MTHI)) begin
            r_hi <= a;
        end else if (w_accept && (op == MDU_OP_MTLO)) begin
            r_lo <= a;
        end else if ((r_state == FIN) && w_fin_wr) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
        end
    end

    // One-cycle completion pulse with its divide-by-zero qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= (r_state == FIN);
            r_div_zero <= (r_state == FIN) && w_fin_dz;
        end
    end

`ifndef SYNTHESIS
    // Flag an undefined opcode presented with an accepted request
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && !mdu_op_valid(op))
            $display("muldiv: invalid op %0d ignored at time %0t", op, $time);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv
// Description : Self-checking bench for muldiv (WORD_SIZE = 32). Expected
//               HI/LO/div_zero results are pushed to a scoreboard queue when
//               a request is driven and popped when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    muldiv #(.WORD_SIZE(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: computes the architectural HI/LO after an operation
    task automatic push_expect(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = 1'b0;
        case (o)
            MDU_OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_OP_MULT: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                if (y == '0) begin
                    e.hi = x;
                    e.lo = '1;
                    e.dz = 1'b1;
                end else begin : g_div_model
                    longint sx, sy, q, r;
                    if (o == MDU_OP_DIV) begin
                        sx = longint'($signed(x));
                        sy = longint'($signed(y));
                    end else begin
                        sx = longint'({32'b0, x});
                        sy = longint'({32'b0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
`else
                e.dz = 1'b1;
`endif
            end
            default: ;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
        sb_q.push_back(e);
    endtask

    // Called just after an acceptance edge; returns at the negedge of the done cycle
    task automatic wait_done(input string tag, input logic [W-1:0] ph, input logic [W-1:0] pl);
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done) begin
                chk({tag, " busy"}, 64'(busy), 64'd1);
                chk({tag, " hold"}, {hi, lo}, {ph, pl});
            end
        end while (!done && lat < LAT + 8);
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        chk({tag, " queued"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, " hi"}, 64'(hi), 64'(e.hi));
            chk({tag, " lo"}, 64'(lo), 64'(e.lo));
            chk({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
        end
        chk({tag, " idle_on_done"}, 64'(busy), 64'd0);
    endtask

    task automatic done_low(input string tag);
        @(negedge clk);
        chk({tag, " done_drop"}, 64'(done), 64'd0);
        chk({tag, " dz_drop"}, 64'(div_zero), 64'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string tag);
        logic [W-1:0] ph, pl;
        ph = m_hi;
        pl = m_lo;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        push_expect(o, x, y);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = o ^ 3'd1;
        a     = ~x;
        b     = y ^ 32'h5A5A_5A5A;
        wait_done(tag, ph, pl);
        done_low(tag);
    endtask

    task automatic do_move(input logic [2:0] o, input logic [W-1:0] x, input string tag);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == MDU_OP_MTHI) m_hi = x;
        else                  m_lo = x;
        chk({tag, " hi"}, 64'(hi), 64'(m_hi));
        chk({tag, " lo"}, 64'(lo), 64'(m_lo));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, " no_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ph, pl;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst div_zero", 64'(div_zero), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // Multiply and divide patterns
        do_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(MDU_OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
        do_op(MDU_OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
        do_op(MDU_OP_MULTU, 32'h0000_0000, 32'h1234_5678, "multu_zero");
        do_op(MDU_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        do_op(MDU_OP_DIVU,  32'd100,       32'd7,         "divu_100_7");
        do_op(MDU_OP_DIVU,  32'h0000_1234, 32'h0000_0000, "divu_zero");
        do_op(MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(MDU_OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, "div_negb");

        // Direct moves
        do_move(MDU_OP_MTHI, 32'hA5A5_A5A5, "mthi");
        do_move(MDU_OP_MTLO, 32'h3C3C_3C3C, "mtlo");

        // Undefined opcode is ignored
        @(negedge clk);
        start = 1'b1;
        op    = 3'd7;
        a     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("invalid busy", 64'(busy), 64'd0);
        chk("invalid hilo", {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        chk("invalid no_done", 64'(done), 64'd0);

        // Start held through busy: second request accepted on the done cycle
        ph = m_hi;
        pl = m_lo;
        @(negedge clk);
        start = 1'b1;
        op    = MDU_OP_MULTU;
        a     = 32'd3;
        b     = 32'd5;
        push_expect(MDU_OP_MULTU, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        a = 32'd7;
        b = 32'd9;
        wait_done("held_first", ph, pl);
        ph = m_hi;
        pl = m_lo;
        push_expect(MDU_OP_MULTU, 32'd7, 32'd9);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("held_second", ph, pl);
        done_low("held_second");

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        start = 1'b1;
        op    = MDU_OP_MULTU;
        a     = 32'h1111_1111;
        b     = 32'h0000_0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("abort no_done", 64'(done), 64'd0);
        end
        do_op(MDU_OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
